// File: rtl/seg7_scanner_if.sv
// Pin-level bundle between the digit-word source and the display back-end.
// The master side supplies the eight digit words. The slave side drives the anode, segment and decimal-point pins.
interface seg7_scanner_if;
   logic [5:0] led0;
   logic [5:0] led1;
   logic [5:0] led2;
   logic [5:0] led3;
   logic [5:0] led4;
   logic [5:0] led5;
   logic [5:0] led6;
   logic [5:0] led7;
   logic [7:0] an;
   logic [6:0] seg;
   logic       dp;

   modport master (
      output led0, led1, led2, led3, led4, led5, led6, led7,
      input  an, seg, dp
   );

   modport slave (
      input  led0, led1, led2, led3, led4, led5, led6, led7,
      output an, seg, dp
   );
endinterface

// File: rtl/seg7_scanner.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Each digit slot starts with one blanked dead-time cycle, which stops the previous digit from ghosting.
// The rest of the slot drives the selected digit with hex decode, a decimal point and optional blink gating.
// All pin outputs are registered.
module seg7_scanner #(
   parameter int SCAN_DIV  = 100000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic           clk,
   input  logic           rst,
   seg7_scanner_if.slave  bus
);

   localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   logic [SW-1:0] scan_cnt;
   logic [2:0]    idx;
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;

   logic [5:0]    led_word [8];
   logic [5:0]    led_cur;
   logic [6:0]    seg_dec;
   logic [7:0]    an_d;
   logic [6:0]    seg_d;
   logic          dp_d;

   assign led_word[0] = bus.led0;
   assign led_word[1] = bus.led1;
   assign led_word[2] = bus.led2;
   assign led_word[3] = bus.led3;
   assign led_word[4] = bus.led4;
   assign led_word[5] = bus.led5;
   assign led_word[6] = bus.led6;
   assign led_word[7] = bus.led7;
   assign led_cur     = led_word[idx];

   // Slot timer: advance to the next digit on the last cycle of each slot.
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else if (scan_cnt == SCAN_LAST) begin
         scan_cnt <= '0;
         idx      <= idx + 3'd1;
      end else begin
         scan_cnt <= scan_cnt + SW'(1);
      end
   end

   // Free-running blink half-period timer, independent of the scan timer.
   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + BW'(1);
      end
   end

   // Hex decode to active-low {g,f,e,d,c,b,a}; code F is reserved as blank.
   always_comb begin
      seg_dec = 7'h7F;
      case (led_cur[3:0])
         4'h0: seg_dec = 7'h40;
         4'h1: seg_dec = 7'h79;
         4'h2: seg_dec = 7'h24;
         4'h3: seg_dec = 7'h30;
         4'h4: seg_dec = 7'h19;
         4'h5: seg_dec = 7'h12;
         4'h6: seg_dec = 7'h02;
         4'h7: seg_dec = 7'h78;
         4'h8: seg_dec = 7'h00;
         4'h9: seg_dec = 7'h10;
         4'hA: seg_dec = 7'h08;
         4'hB: seg_dec = 7'h03;
         4'hC: seg_dec = 7'h46;
         4'hD: seg_dec = 7'h21;
         4'hE: seg_dec = 7'h06;
         default: seg_dec = 7'h7F;
      endcase
   end

   // Next pin values. Everything is dark in the dead cycle.
   // During the blink-off phase the segments are blanked but the anode stays on, so scan timing is unchanged.
   always_comb begin
      an_d  = 8'hFF;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (scan_cnt != '0) begin
         an_d = ~(8'b1 << idx);
         if (!(led_cur[5] && blink_phase)) begin
            seg_d = seg_dec;
            dp_d  = ~led_cur[4];
         end
      end
   end

   // Pin registers; these use the counter values present before the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.an  <= 8'hFF;
         bus.seg <= 7'h7F;
         bus.dp  <= 1'b1;
      end else begin
         bus.an  <= an_d;
         bus.seg <= seg_d;
         bus.dp  <= dp_d;
      end
   end

endmodule

// File: tb/tb_seg7_scanner.sv
// Bench for seg7_scanner.
// The reference model works from the edge count since reset release:
// slot position, digit number and blink phase all come from plain division of that count.
module tb_seg7_scanner;
   localparam int SCAN_DIV  = 4;
   localparam int BLINK_DIV = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [5:0] led [8];

   seg7_scanner_if bus ();

   seg7_scanner #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.led0 = led[0];
   assign bus.led1 = led[1];
   assign bus.led2 = led[2];
   assign bus.led3 = led[3];
   assign bus.led4 = led[4];
   assign bus.led5 = led[5];
   assign bus.led6 = led[6];
   assign bus.led7 = led[7];

   always #5 clk = ~clk;

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h7F};

   int k = 0;
   int total = 0;
   int bad = 0;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h (edge %0d)", tag, obs, exp, k);
      end
   endtask

   task automatic step();
      logic [7:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      int         d;
      bit         ph;
      @(posedge clk);
      e_an  = 8'hFF;
      e_seg = 7'h7F;
      e_dp  = 1'b1;
      if (rst) begin
         k = 0;
      end else begin
         d  = (k / SCAN_DIV) % 8;
         ph = ((k / BLINK_DIV) % 2) == 1;
         if ((k % SCAN_DIV) != 0) begin
            e_an  = ~(8'h01 << d);
            e_seg = seg_tab[led[d][3:0]];
            e_dp  = ~led[d][4];
            if (led[d][5] && ph) begin
               e_seg = 7'h7F;
               e_dp  = 1'b1;
            end
         end
         k++;
      end
      #1;
      chk("an",  {8'h00, bus.an},  {8'h00, e_an});
      chk("seg", {9'h000, bus.seg}, {9'h000, e_seg});
      chk("dp",  {15'h0000, bus.dp}, {15'h0000, e_dp});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   task automatic rand_leds();
      for (int i = 0; i < 8; i++) led[i] = 6'($urandom);
   endtask

   task automatic set_leds(input logic [5:0] v);
      for (int i = 0; i < 8; i++) led[i] = v;
   endtask

   initial begin
      // Reset held for three edges with arbitrary inputs
      rand_leds();
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         rand_leds();
      end
      rst = 1'b0;

      // Scan order with led_i = i
      for (int i = 0; i < 8; i++) led[i] = 6'(i);
      for (int i = 0; i < 40; i++) step();

      // Random words, changed every cycle, including blink and dot bits
      for (int i = 0; i < 200; i++) begin
         rand_leds();
         step();
      end

      // Reset mid-slot while digit 5 is active, then check the scan restarts at digit 0
      do_reset();
      rand_leds();
      while (k < 5 * SCAN_DIV + 2) step();
      rst = 1'b1;
      step();
      chk("midslot_rst_an", {8'h00, bus.an}, 16'h00FF);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) led[i] = 6'(i);
      step();
      step();
      chk("restart_an", {8'h00, bus.an}, 16'h00FE);

      // Every code on digit 0
      for (int c = 0; c < 16; c++) begin
         do_reset();
         set_leds(6'h00);
         led[0] = {2'b00, 4'(c)};
         step();
         step();
         chk("decode", {9'h000, bus.seg}, {9'h000, seg_tab[c]});
      end

      // Decimal point on digit 3 only
      set_leds(6'h00);
      led[3] = 6'b01_0101;
      do_reset();
      for (int i = 0; i < 40; i++) step();

      // Blinking digit 2 over several blink phases
      set_leds(6'h01);
      led[2] = 6'b11_1000;
      do_reset();
      for (int i = 0; i < 64; i++) step();

      // Live update within slot 4
      set_leds(6'h00);
      led[4] = 6'h01;
      do_reset();
      while (k < 4 * SCAN_DIV + 2) step();
      chk("live_before", {9'h000, bus.seg}, 16'h0079);
      led[4] = 6'h07;
      step();
      chk("live_after_seg", {9'h000, bus.seg}, 16'h0078);
      chk("live_after_an", {8'h00, bus.an}, 16'h00EF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/seg7_scanner.md
Name: seg7_scanner

Overview:
- Display back-end downstream of led_interface.
- Takes the eight 6-bit digit words {blink, dot, code[3:0]} that led_interface produces and time-multiplexes them onto one 8-digit common-anode seven-segment display.
- Provides hex/blank decoding, per-digit decimal point, per-digit blink gating, and one dead-time cycle between digits to suppress ghosting.
- All outputs are registered and drive board pins directly.

Parameters:
- SCAN_DIV, 100000, clk cycles per digit slot; legal values >= 2; use 4 in simulation.
- BLINK_DIV, 25000000, clk cycles per blink half-period; legal values >= 1; use 8 in simulation.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- led0  input  6  digit 0, rightmost: [5]=blink, [4]=dot, [3:0]=code.
- led1 .. led7  input  6 each  digits 1..7, same format; led7 is leftmost.
- an  output  8  anode enables, active-low; an[i] selects digit i.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.

Behaviour:
- Reset (rst=1 at a rising edge):
  - scan_cnt=0, idx=0, blink_cnt=0, blink_phase=0.
  - an=8'hFF, seg=7'h7F, dp=1.
  - Takes effect from any state, including mid-slot.
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1, then wraps to 0.
  - When scan_cnt==SCAN_DIV-1, idx increments mod 8 (7 wraps to 0).
  - Scan order: 0,1,...,7,0,...
- Output register, loaded every edge when rst=0:
  - If scan_cnt==0 (dead-time cycle): an=8'hFF, seg=7'h7F, dp=1.
  - Otherwise: an=~(8'b1<<idx), seg=decode(code[idx]), dp=~dot[idx].
  - When blink[idx]=1 and blink_phase=1, force seg=7'h7F and dp=1 while keeping the anode active.
- Slot timing:
  - Each slot is 1 dead cycle followed by SCAN_DIV-1 active cycles.
  - After reset release, the first dead-time load happens at the first edge; digit 0 is driven from the 2nd edge.
  - Frame length is 8*SCAN_DIV cycles.
- Input sampling and latency:
  - Inputs are sampled live every cycle, with no slot-start latching.
  - A change on led[idx] appears on seg/dp at the next edge (1-cycle latency).
- Decode table (hex, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06
  - F = blank, 7F
- Blink generator:
  - blink_cnt counts 0..BLINK_DIV-1, free-running and independent of the scan counter.
  - At the terminal count, blink_cnt wraps to 0 and blink_phase toggles.
  - blink_phase is 0 for the first BLINK_DIV cycles after reset, then 1 for the next BLINK_DIV, and so on.
- Simultaneous events:
  - A scan wrap and a blink toggle on the same edge are independent; both update.
  - The output loaded on that edge uses the pre-update idx and blink_phase, i.e. the values present before that edge.
- Encodings:
  - Exactly one an bit is low in active cycles; none is low in dead cycles or in reset.
  - No X on any output after the first reset edge.

Test Plan:
- Reset: hold rst=1 for 3 edges with arbitrary inputs -> an=FF, seg=7F, dp=1. Assert rst=1 mid-slot at idx=5 -> next edge shows an=FF, and scanning restarts at digit 0.
- Scan order (SCAN_DIV=4, BLINK_DIV=8, no blink bits set, led_i={0,0,i}):
  - Per slot: 1 cycle an=FF, then 3 cycles with an=FE and seg=40.
  - Subsequent slots: an=FD/seg=79, ..., an=7F/seg=78.
  - Frame repeats after 32 cycles.
- Decode: drive led0 codes 0x0..0xF in turn while digit 0 is active -> seg matches the table each time; 0xF gives 7F.
- Dot: led3=6'b01_0101 -> during slot 3, an=F7, seg=12, dp=0. In every other slot, and in dead cycles, dp=1.
- Blink (BLINK_DIV=8): led2=6'b11_1000 -> digit-2 active cycles show seg=00/dp=0 while blink_phase=0 and seg=7F/dp=1 while blink_phase=1, with an=FB throughout. Non-blinking digits are unaffected.
- Live update: change led4 from code 1 to code 7 in the middle of slot 4 -> seg changes from 79 to 78 one edge later, within the same slot.
